// File: rtl/pn_ingress_pkg.sv
// rtl/pn_ingress_pkg.sv - address field constants, FSM states and beat type for the PN ingress arbiter
package pn_ingress_pkg;

   localparam int PARAM_BIT = 15;
   localparam int RC_BIT    = 14;
   localparam int N2_HI     = 13;
   localparam int N2_LO     = 7;
   localparam int N1_HI     = 6;
   localparam int N1_LO     = 0;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_SPLIT2 = 1'b1
   } state_e;

   typedef struct packed {
      logic [15:0] addr;
      logic [31:0] data;
      logic        swu;
   } beat_t;

   // A spike word that names a second neuron must leave as two beats.
   function automatic logic is_dual_spike(input logic [15:0] addr);
      return !addr[PARAM_BIT] && !addr[RC_BIT] && (addr[N2_HI:N2_LO] != 7'd0);
   endfunction

endpackage

// File: rtl/pn_ingress_if.sv
// rtl/pn_ingress_if.sv - AXI write, SWU request and output beat handshakes of the PN ingress arbiter
interface pn_ingress_if;

   logic        axi_valid;
   logic        axi_ready;
   logic [15:0] axi_addr;
   logic [31:0] axi_data;

   logic        swu_valid;
   logic        swu_ready;
   logic [15:0] swu_addr;
   logic [7:0]  swu_data;

   logic        o_valid;
   logic        o_ready;
   logic [15:0] o_addr;
   logic [31:0] o_data;
   logic        o_swu;

   modport slave (
      input  axi_valid, axi_addr, axi_data,
      output axi_ready,
      input  swu_valid, swu_addr, swu_data,
      output swu_ready,
      output o_valid, o_addr, o_data, o_swu,
      input  o_ready
   );

   modport master (
      output axi_valid, axi_addr, axi_data,
      input  axi_ready,
      output swu_valid, swu_addr, swu_data,
      input  swu_ready,
      input  o_valid, o_addr, o_data, o_swu,
      output o_ready
   );

endinterface

// File: rtl/pn_sync_fifo.sv
// rtl/pn_sync_fifo.sv - single-clock FIFO with level, full/empty and synchronous flush
module pn_sync_fifo #(
   parameter  int WIDTH = 48,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             kill,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // The extra pointer bit lets level reach DEPTH without ambiguity.
   assign level   = wr_ptr - rd_ptr;
   assign full    = (level == FULL_LEVEL);
   assign empty   = (level == '0);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Pointer advance; a write to a full FIFO is refused even if a pop happens too.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (kill) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_en && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage array, written only when the entry is actually accepted.
   always_ff @(posedge clk) begin
      if (wr_en && !full && !kill)
         mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/pn_ingress_arbiter.sv
// rtl/pn_ingress_arbiter.sv - buffers AXI writes, arbitrates against SWU and splits dual-neuron spikes
module pn_ingress_arbiter
   import pn_ingress_pkg::*;
#(
   parameter int DEPTH         = 8,
   parameter int SWU_BURST_MAX = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   kill,
   pn_ingress_if.slave            bus,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic [15:0]            drop_cnt
);

   localparam int             SW         = $clog2(SWU_BURST_MAX + 1);
   localparam logic [SW-1:0]  STREAK_MAX = SW'(SWU_BURST_MAX);

   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_wr;
   logic [47:0] fifo_rdata;
   logic [15:0] head_addr;
   logic [31:0] head_data;
   logic        head_split;

   state_e        state;
   beat_t         out_q;
   beat_t         split_q;
   beat_t         next_beat;
   logic          out_valid;
   logic [SW-1:0] swu_streak;

   logic can_load;
   logic burst_cap;
   logic grant_swu;
   logic grant_fifo;
   logic load_split;

   assign fifo_wr       = bus.axi_valid && !fifo_full;
   assign bus.axi_ready = !fifo_full;

   pn_sync_fifo #(
      .WIDTH (48),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .kill    (kill),
      .wr_en   (fifo_wr),
      .wr_data ({bus.axi_addr, bus.axi_data}),
      .rd_en   (grant_fifo),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign {head_addr, head_data} = fifo_rdata;
   assign head_split             = is_dual_spike(head_addr);

   // The output register takes a new beat when empty or when its beat leaves this cycle.
   assign can_load   = !out_valid || bus.o_ready;
   assign burst_cap  = (swu_streak == STREAK_MAX) && !fifo_empty;
   assign grant_swu  = (state == ST_IDLE) && can_load && bus.swu_valid && !burst_cap;
   assign grant_fifo = (state == ST_IDLE) && can_load && !grant_swu && !fifo_empty;
   assign load_split = (state == ST_SPLIT2) && can_load;

   assign bus.swu_ready = grant_swu;
   assign bus.o_valid   = out_valid;
   assign bus.o_addr    = out_q.addr;
   assign bus.o_data    = out_q.data;
   assign bus.o_swu     = out_q.swu;

   // Select the beat for the output register: pending second half, SWU, or FIFO head.
   always_comb begin
      next_beat = '0;
      if (load_split) begin
         next_beat = split_q;
      end else if (grant_swu) begin
         next_beat.addr = bus.swu_addr;
         next_beat.data = {24'b0, bus.swu_data};
         next_beat.swu  = 1'b1;
      end else if (grant_fifo) begin
         next_beat.addr = head_split ? {9'b0, head_addr[N1_HI:N1_LO]} : head_addr;
         next_beat.data = head_data;
         next_beat.swu  = 1'b0;
      end
   end

   // Output register: holds a beat stable until the consumer accepts it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q     <= '0;
         out_valid <= 1'b0;
      end else if (kill) begin
         out_q     <= '0;
         out_valid <= 1'b0;
      end else if (load_split || grant_swu || grant_fifo) begin
         out_q     <= next_beat;
         out_valid <= 1'b1;
      end else if (out_valid && bus.o_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Split FSM: park the second neuron of a dual spike until it can be emitted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         split_q <= '0;
      end else if (kill) begin
         state   <= ST_IDLE;
         split_q <= '0;
      end else if (grant_fifo && head_split) begin
         state        <= ST_SPLIT2;
         split_q.addr <= {9'b0, head_addr[N2_HI:N2_LO]};
         split_q.data <= head_data;
         split_q.swu  <= 1'b0;
      end else if (load_split) begin
         state <= ST_IDLE;
      end
   end

   // SWU streak: bounds consecutive SWU grants while AXI traffic is waiting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         swu_streak <= '0;
      end else if (kill) begin
         swu_streak <= '0;
      end else if (grant_swu) begin
         if (swu_streak != STREAK_MAX)
            swu_streak <= swu_streak + 1'b1;
      end else if (grant_fifo) begin
         swu_streak <= '0;
      end
   end

   // Drop counter: saturating count of cycles an AXI beat met a full FIFO; survives kill.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         drop_cnt <= '0;
      else if (bus.axi_valid && fifo_full && (drop_cnt != 16'hFFFF))
         drop_cnt <= drop_cnt + 16'd1;
   end

endmodule

// File: tb/tb_pn_ingress_arbiter.sv
// tb/tb_pn_ingress_arbiter.sv - self-checking bench for pn_ingress_arbiter with a queue-based reference model
module tb_pn_ingress_arbiter;

   localparam int DEPTH   = 8;
   localparam int SWU_MAX = 4;

   logic        clk;
   logic        rst;
   logic        kill;
   logic [3:0]  fifo_level;
   logic [15:0] drop_cnt;

   pn_ingress_if bus ();

   pn_ingress_arbiter #(
      .DEPTH         (DEPTH),
      .SWU_BURST_MAX (SWU_MAX)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .kill       (kill),
      .bus        (bus),
      .fifo_level (fifo_level),
      .drop_cnt   (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run;
   int tests_failed;

   // Reference model: FIFO as a queue, the output register as plain variables.
   logic [47:0] m_fifo [$];
   bit          m_ov;
   logic [15:0] m_addr;
   logic [31:0] m_data;
   bit          m_swu;
   bit          m_pend;
   logic [15:0] m_pend_addr;
   logic [31:0] m_pend_data;
   int          m_streak;
   int          m_drop;
   bit          exp_axi_ready;
   bit          exp_swu_ready;
   logic        seen_axi_ready;
   logic        seen_swu_ready;

   task automatic model_reset();
      m_fifo.delete();
      m_ov = 0; m_addr = '0; m_data = '0; m_swu = 0;
      m_pend = 0; m_streak = 0; m_drop = 0;
   endtask

   task automatic model_step();
      bit          can_load;
      logic [47:0] h;
      logic [15:0] ha;
      int          n1;
      int          n2;
      can_load      = !m_ov || bus.o_ready;
      exp_axi_ready = m_fifo.size() < DEPTH;
      exp_swu_ready = !m_pend && can_load && bus.swu_valid &&
                      !(m_streak == SWU_MAX && m_fifo.size() > 0);
      if (bus.axi_valid && !exp_axi_ready && m_drop < 65535)
         m_drop++;
      if (kill) begin
         m_fifo.delete();
         m_ov = 0; m_addr = '0; m_data = '0; m_swu = 0;
         m_pend = 0; m_streak = 0;
         return;
      end
      if (m_ov && bus.o_ready)
         m_ov = 0;
      if (can_load) begin
         if (m_pend) begin
            m_ov = 1; m_addr = m_pend_addr; m_data = m_pend_data; m_swu = 0;
            m_pend = 0;
         end else if (exp_swu_ready) begin
            m_ov = 1; m_addr = bus.swu_addr; m_data = {24'h0, bus.swu_data}; m_swu = 1;
            if (m_streak < SWU_MAX)
               m_streak++;
         end else if (m_fifo.size() > 0) begin
            h = m_fifo.pop_front();
            ha = h[47:32];
            m_streak = 0;
            n1 = ha % 128;
            n2 = (ha / 128) % 128;
            m_ov = 1; m_data = h[31:0]; m_swu = 0;
            if (ha >= 16'h4000 || n2 == 0) begin
               m_addr = ha;
            end else begin
               m_addr = 16'(n1);
               m_pend = 1; m_pend_addr = 16'(n2); m_pend_data = h[31:0];
            end
         end
      end
      if (bus.axi_valid && exp_axi_ready)
         m_fifo.push_back({bus.axi_addr, bus.axi_data});
   endtask

   // One clock: sample combinational readies mid-cycle, advance the model, settle after the edge.
   task automatic tick();
      @(negedge clk);
      seen_axi_ready = bus.axi_ready;
      seen_swu_ready = bus.swu_ready;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      kill = 1'b0;
      bus.axi_valid = 1'b0; bus.axi_addr = '0; bus.axi_data = '0;
      bus.swu_valid = 1'b0; bus.swu_addr = '0; bus.swu_data = '0;
      bus.o_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.axi_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_axi_ready got %0b want 1", bus.axi_ready); end
      tests_run++;
      if (bus.swu_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_swu_ready got %0b want 0", bus.swu_ready); end
      tests_run++;
      if (bus.o_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_o_valid got %0b want 0", bus.o_valid); end
      tests_run++;
      if ({bus.o_addr, bus.o_data, bus.o_swu} !== 49'h0) begin
         tests_failed++; $display("FAIL reset_o_beat got %h/%h/%0b want 0/0/0", bus.o_addr, bus.o_data, bus.o_swu);
      end
      tests_run++;
      if (fifo_level !== 4'd0) begin tests_failed++; $display("FAIL reset_level got %0d want 0", fifo_level); end
      tests_run++;
      if (drop_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
   endtask

   task automatic test_param_write();
      idle_inputs();
      bus.axi_valid = 1'b1; bus.axi_addr = 16'h8015; bus.axi_data = 32'hDEAD_BEEF;
      tick();
      bus.axi_valid = 1'b0;
      tests_run++;
      if (bus.o_valid !== 1'b0 || fifo_level !== 4'd1) begin
         tests_failed++; $display("FAIL param_write_edge got valid=%0b level=%0d want 0/1", bus.o_valid, fifo_level);
      end
      tick();
      tests_run++;
      if (bus.o_valid !== 1'b1 || bus.o_addr !== 16'h8015 || bus.o_data !== 32'hDEAD_BEEF || bus.o_swu !== 1'b0) begin
         tests_failed++;
         $display("FAIL param_write_beat got v=%0b a=%h d=%h s=%0b want 1/8015/deadbeef/0", bus.o_valid, bus.o_addr, bus.o_data, bus.o_swu);
      end
      tick();
      tests_run++;
      if (bus.o_valid !== 1'b0) begin tests_failed++; $display("FAIL param_write_drain got %0b want 0", bus.o_valid); end
   endtask

   task automatic test_split();
      logic [15:0] want [3];
      idle_inputs();
      bus.axi_valid = 1'b1; bus.axi_addr = 16'h0283; bus.axi_data = 32'd5;
      tick();
      bus.axi_valid = 1'b0;
      want[0] = 16'h0003; want[1] = 16'h0005;
      for (int i = 0; i < 2; i++) begin
         tick();
         tests_run++;
         if (bus.o_valid !== 1'b1 || bus.o_addr !== want[i] || bus.o_data !== 32'd5 || bus.o_swu !== 1'b0) begin
            tests_failed++;
            $display("FAIL split_beat%0d got v=%0b a=%h d=%h want 1/%h/5", i, bus.o_valid, bus.o_addr, bus.o_data, want[i]);
         end
      end
      tick();
      tests_run++;
      if (bus.o_valid !== 1'b0) begin tests_failed++; $display("FAIL split_end got %0b want 0", bus.o_valid); end
      bus.axi_valid = 1'b1; bus.axi_addr = 16'h0003; bus.axi_data = 32'd7;
      tick();
      bus.axi_valid = 1'b0;
      tick();
      tests_run++;
      if (bus.o_valid !== 1'b1 || bus.o_addr !== 16'h0003 || bus.o_data !== 32'd7) begin
         tests_failed++; $display("FAIL single_spike got v=%0b a=%h d=%h want 1/0003/7", bus.o_valid, bus.o_addr, bus.o_data);
      end
      tick();
      tests_run++;
      if (bus.o_valid !== 1'b0) begin tests_failed++; $display("FAIL single_spike_end got %0b want 0", bus.o_valid); end
   endtask

   task automatic test_swu_burst();
      logic [15:0] wa;
      logic [31:0] wd;
      logic        ws;
      logic        wr;
      idle_inputs();
      bus.swu_valid = 1'b1; bus.swu_addr = 16'h0011; bus.swu_data = 8'h7F;
      for (int k = 0; k < 10; k++) begin
         bus.axi_valid = (k < 3);
         bus.axi_addr  = 16'h8001 + 16'(k);
         bus.axi_data  = 32'h1000_0001 + 32'(k);
         tick();
         if (k == 4)      begin wa = 16'h8001; wd = 32'h1000_0001; ws = 1'b0; end
         else if (k == 9) begin wa = 16'h8002; wd = 32'h1000_0002; ws = 1'b0; end
         else             begin wa = 16'h0011; wd = 32'h0000_007F; ws = 1'b1; end
         wr = ws;
         tests_run++;
         if (bus.o_valid !== 1'b1 || bus.o_addr !== wa || bus.o_data !== wd || bus.o_swu !== ws) begin
            tests_failed++;
            $display("FAIL swu_burst_beat%0d got v=%0b a=%h d=%h s=%0b want 1/%h/%h/%0b", k, bus.o_valid, bus.o_addr, bus.o_data, bus.o_swu, wa, wd, ws);
         end
         tests_run++;
         if (seen_swu_ready !== wr) begin
            tests_failed++; $display("FAIL swu_burst_ready%0d got %0b want %0b", k, seen_swu_ready, wr);
         end
      end
      bus.axi_valid = 1'b0;
      bus.swu_valid = 1'b0;
      tick();
      tests_run++;
      if (bus.o_valid !== 1'b1 || bus.o_addr !== 16'h8003 || bus.o_swu !== 1'b0) begin
         tests_failed++; $display("FAIL swu_burst_tail got v=%0b a=%h s=%0b want 1/8003/0", bus.o_valid, bus.o_addr, bus.o_swu);
      end
      tick();
      tests_run++;
      if (bus.o_valid !== 1'b0 || fifo_level !== 4'd0) begin
         tests_failed++; $display("FAIL swu_burst_end got v=%0b level=%0d want 0/0", bus.o_valid, fifo_level);
      end
   endtask

   task automatic test_backpressure();
      int          idx_w;
      int          idx_r;
      int          full_cycles;
      int          max_level;
      logic [15:0] d0;
      logic        av;
      idle_inputs();
      idx_w = 0; idx_r = 0; full_cycles = 0; max_level = 0;
      d0 = drop_cnt;
      for (int cyc = 0; cyc < 80 && idx_r < 12; cyc++) begin
         bus.o_ready   = (cyc >= 10);
         bus.axi_valid = (idx_w < 12);
         bus.axi_addr  = 16'h8000 + 16'(idx_w);
         bus.axi_data  = 32'hB0 + 32'(idx_w);
         av = bus.axi_valid;
         if (bus.o_valid && bus.o_ready) begin
            tests_run++;
            if (bus.o_addr !== 16'h8000 + 16'(idx_r) || bus.o_data !== 32'hB0 + 32'(idx_r)) begin
               tests_failed++;
               $display("FAIL backpressure_order%0d got %h/%h want %h/%h", idx_r, bus.o_addr, bus.o_data, 16'h8000 + 16'(idx_r), 32'hB0 + 32'(idx_r));
            end
            idx_r++;
         end
         tick();
         if (av && seen_axi_ready) idx_w++;
         else if (av) full_cycles++;
         if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      end
      tests_run++;
      if (idx_r != 12) begin tests_failed++; $display("FAIL backpressure_drained got %0d beats want 12", idx_r); end
      tests_run++;
      if (max_level != DEPTH) begin tests_failed++; $display("FAIL backpressure_level got %0d want %0d", max_level, DEPTH); end
      tests_run++;
      if (full_cycles != 2) begin tests_failed++; $display("FAIL backpressure_full_cycles got %0d want 2", full_cycles); end
      tests_run++;
      if (drop_cnt - d0 !== 16'd2) begin tests_failed++; $display("FAIL backpressure_drop got %0d want 2", drop_cnt - d0); end
   endtask

   task automatic test_split_swu();
      idle_inputs();
      bus.axi_valid = 1'b1; bus.axi_addr = 16'h0283; bus.axi_data = 32'd9;
      tick();
      bus.axi_valid = 1'b0;
      tick();
      bus.swu_valid = 1'b1; bus.swu_addr = 16'h0011; bus.swu_data = 8'h22;
      bus.o_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         tests_run++;
         if (seen_swu_ready !== 1'b0 || bus.o_addr !== 16'h0003 || bus.o_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL split_swu_hold%0d got rdy=%0b a=%h v=%0b want 0/0003/1", i, seen_swu_ready, bus.o_addr, bus.o_valid);
         end
      end
      bus.o_ready = 1'b1;
      tick();
      tests_run++;
      if (seen_swu_ready !== 1'b0 || bus.o_addr !== 16'h0005 || bus.o_data !== 32'd9 || bus.o_swu !== 1'b0) begin
         tests_failed++;
         $display("FAIL split_swu_second got rdy=%0b a=%h d=%h s=%0b want 0/0005/9/0", seen_swu_ready, bus.o_addr, bus.o_data, bus.o_swu);
      end
      tick();
      tests_run++;
      if (seen_swu_ready !== 1'b1 || bus.o_swu !== 1'b1 || bus.o_addr !== 16'h0011 || bus.o_data !== 32'h22) begin
         tests_failed++;
         $display("FAIL split_swu_grant got rdy=%0b s=%0b a=%h d=%h want 1/1/0011/22", seen_swu_ready, bus.o_swu, bus.o_addr, bus.o_data);
      end
      bus.swu_valid = 1'b0;
      tick();
   endtask

   task automatic test_kill();
      logic [15:0] d0;
      idle_inputs();
      bus.o_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.axi_valid = 1'b1; bus.axi_addr = 16'h8100 + 16'(i); bus.axi_data = 32'(i);
         tick();
      end
      bus.axi_valid = 1'b0;
      tests_run++;
      if (bus.o_valid !== 1'b1 || fifo_level !== 4'd5) begin
         tests_failed++; $display("FAIL kill_setup got v=%0b level=%0d want 1/5", bus.o_valid, fifo_level);
      end
      d0 = drop_cnt;
      kill = 1'b1;
      bus.axi_valid = 1'b1; bus.axi_addr = 16'h8200; bus.axi_data = 32'h55;
      tick();
      kill = 1'b0;
      bus.axi_valid = 1'b0;
      tests_run++;
      if (bus.o_valid !== 1'b0 || fifo_level !== 4'd0 || drop_cnt !== d0) begin
         tests_failed++;
         $display("FAIL kill_flush got v=%0b level=%0d drop=%0d want 0/0/%0d", bus.o_valid, fifo_level, drop_cnt, d0);
      end
      bus.o_ready = 1'b1;
      tick();
      tests_run++;
      if (bus.o_valid !== 1'b0 || fifo_level !== 4'd0) begin
         tests_failed++; $display("FAIL kill_after got v=%0b level=%0d want 0/0", bus.o_valid, fifo_level);
      end
   endtask

   task automatic test_random();
      logic [15:0] a;
      int          ready_pct;
      idle_inputs();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         ready_pct = ((cyc / 150) % 2 == 1) ? 90 : 30;
         case ($urandom_range(0, 3))
            0:       a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
            1:       a = 16'h4000 | 16'($urandom_range(0, 16'h3FFF));
            2:       a = 16'($urandom_range(0, 127));
            default: a = 16'($urandom_range(0, 16'h3FFF));
         endcase
         bus.axi_valid = ($urandom_range(0, 99) < 70);
         bus.axi_addr  = a;
         bus.axi_data  = $urandom;
         bus.swu_valid = ($urandom_range(0, 99) < 40);
         bus.swu_addr  = 16'($urandom);
         bus.swu_data  = 8'($urandom);
         bus.o_ready   = ($urandom_range(0, 99) < ready_pct);
         kill          = ($urandom_range(0, 99) == 0);
         tick();
         tests_run++;
         if (seen_axi_ready !== exp_axi_ready || seen_swu_ready !== exp_swu_ready) begin
            tests_failed++;
            $display("FAIL rand_ready cyc%0d got axi=%0b swu=%0b want %0b/%0b", cyc, seen_axi_ready, seen_swu_ready, exp_axi_ready, exp_swu_ready);
         end
         tests_run++;
         if (bus.o_valid !== m_ov || (m_ov && (bus.o_addr !== m_addr || bus.o_data !== m_data || bus.o_swu !== m_swu))) begin
            tests_failed++;
            $display("FAIL rand_beat cyc%0d got v=%0b a=%h d=%h s=%0b want %0b/%h/%h/%0b", cyc, bus.o_valid, bus.o_addr, bus.o_data, bus.o_swu, m_ov, m_addr, m_data, m_swu);
         end
         tests_run++;
         if (fifo_level !== 4'(m_fifo.size()) || drop_cnt !== 16'(m_drop)) begin
            tests_failed++;
            $display("FAIL rand_counts cyc%0d got level=%0d drop=%0d want %0d/%0d", cyc, fifo_level, drop_cnt, m_fifo.size(), m_drop);
         end
      end
      kill = 1'b0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_param_write();
      test_split();
      test_swu_burst();
      test_backpressure();
      test_split_swu();
      test_kill();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/pn_ingress_arbiter.md
# pn_ingress_arbiter

Sits directly upstream of the PN controller and produces its address/data beat stream. Buffers AXI parameter and spike writes in a FIFO, arbitrates them against STDP synaptic-weight-update (SWU) requests, and splits dual-neuron spike words into two single-neuron beats. This takes stacking and priority out of the controller: every output beat carries exactly one target address.

## Interface
Parameters:
- DEPTH, 8: AXI FIFO entries, power of two, ≥2.
- SWU_BURST_MAX, 4: consecutive SWU grants allowed while the FIFO is non-empty.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- kill, in, 1: synchronous flush, active-high.
- axi_valid, in, 1: AXI write beat present.
- axi_ready, out, 1: equal to !fifo_full.
- axi_addr, in, 16: word address. [15]=param, [14]=rich-club, [13:12]=param target, [13:7]=second neuron for a spike, [6:0]=first neuron.
- axi_data, in, 32: write data.
- swu_valid, in, 1: weight-update request.
- swu_ready, out, 1: SWU request accepted this cycle.
- swu_addr, in, 16: update address.
- swu_data, in, 8: new weight.
- o_valid, out, 1: beat valid.
- o_ready, in, 1: downstream accepts the beat.
- o_addr, out, 16: beat address.
- o_data, out, 32: beat data.
- o_swu, out, 1: beat originates from SWU.
- fifo_level, out, $clog2(DEPTH)+1: current FIFO occupancy.
- drop_cnt, out, 16: saturating count of cycles with axi_valid high and the FIFO full.

## Operation
- FIFO write when axi_valid && axi_ready. No write on a full FIFO, even when a pop happens in the same cycle.
- Output register: a beat loads only when the register is empty, or when o_valid && o_ready fires in the same cycle. o_valid, o_addr, o_data and o_swu stay stable until accepted.
- FSM states: IDLE, SPLIT2.
- IDLE, when the output register can load:
  - Grant SWU if swu_valid, unless swu_streak==SWU_BURST_MAX and the FIFO is non-empty. In that case grant the FIFO head and clear swu_streak.
  - SWU grant: swu_ready=1. o_addr=swu_addr, o_data={24'b0,swu_data}, o_swu=1. swu_streak increments, saturating at SWU_BURST_MAX.
  - FIFO grant with an empty SWU side: swu_streak clears.
  - Popped head with [15]=1 (param) or [14]=1 (rich-club): one beat, address and data unchanged.
  - Popped head that is a spike with [13:7]==0: one beat, unchanged.
  - Popped head that is a spike with [13:7]!=0: emit {9'b0,addr[6:0]} with its data. Latch {9'b0,addr[13:7]} and the data, then go to SPLIT2.
- SPLIT2: the latched second beat loads on the next load opportunity, then the FSM returns to IDLE. SWU is not granted and the FIFO is not popped in SPLIT2, so the pair is never interleaved.
- kill: clears the FIFO pointers, the output register, the FSM (to IDLE), swu_streak and o_valid. drop_cnt is preserved. kill overrides a same-cycle write or grant.
- rst low: everything is cleared, including drop_cnt.

## Timing
- Reset values: axi_ready=1, swu_ready=0, o_valid=0, o_addr=0, o_data=0, o_swu=0, fifo_level=0, drop_cnt=0, FSM=IDLE.
- Latency:
  - AXI write at edge N into an empty, idle block: o_valid at edge N+1, registered FIFO read plus the output register.
  - SWU: swu_ready combinational in cycle N, o_valid after edge N.
- With o_ready held high, throughput is one beat per cycle. A split spike takes two cycles.
- swu_ready depends on swu_valid, the FSM state, and the output register's empty or accepted status. It never depends on axi_valid.
- FIFO pointers wrap modulo DEPTH. fifo_level counts 0..DEPTH.

## Structure
- pn_ingress_pkg holds:
  - the address field constants: PARAM_BIT=15, RC_BIT=14, N2 slice 13:7, N1 slice 6:0;
  - the FSM state enum;
  - the beat struct {addr, data, swu}.
- Sub-module pn_sync_fifo is parameterised in width and depth, with full, empty, level and kill flush. Two instantiations are not needed.

## Test plan
- Reset, then one AXI write with addr 0x8015 and data 0xDEAD_BEEF → one beat with o_addr=0x8015, o_data=0xDEADBEEF, o_swu=0, 1 cycle after the write.
- AXI spike with addr 0x0283 and data 5 → two beats, 0x0003 then 0x0005, both with data 5, on consecutive cycles. A spike with addr 0x0003 → a single beat.
- swu_valid held with addr 0x0011 and data 0x7F while 3 AXI writes are queued, SWU_BURST_MAX=4 → 4 SWU beats with o_data=0x7F, then 1 AXI beat, then SWU resumes.
- o_ready low for 10 cycles while writing 12 entries, DEPTH=8 → axi_ready drops after the FIFO fills, drop_cnt increments on each full cycle, and the beats later drain in order.
- SWU request arriving while the FSM is in SPLIT2 → swu_ready stays 0 until the second spike beat is accepted.
- kill asserted with 5 entries queued and o_valid high → next cycle o_valid=0, fifo_level=0, drop_cnt unchanged.
